muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer in the EX stage of the pipelined core. It accepts one M-extension operation from the decoded R-type slot (funct7[25]=1) and runs a radix-2 shift-add multiply or a restoring divide over XLEN cycles. While busy it stalls IF/ID/EX, then presents the result for one cycle so the instruction can advance to MEM.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  EX holds a valid M-ext instruction
i_funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
i_rs1_data  in  XLEN  operand A, forwarded value
i_rs2_data  in  XLEN  operand B, forwarded value
i_flush  in  1  EX flush from branch/jump redirect
o_stall  out  1  freeze PC, IF/ID and ID/EX registers
o_busy  out  1  state != IDLE
o_valid  out  1  one-cycle result strobe
o_result  out  XLEN  result; valid only when o_valid=1

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counter 0, all internal registers 0. Outputs: o_stall=0, o_busy=0, o_valid=0, o_result=0.
- States:
  - IDLE: i_start=1 and i_flush=0 latches funct3 and operands.
    - Special case detected: go to DONE.
    - Otherwise: capture magnitudes, record result sign, go to CALC.
  - CALC: one iteration per cycle, counter 0..XLEN-1. Leave to SIGN when counter=XLEN-1.
  - SIGN: conditionally two's-complement the selected result. Go to DONE.
  - DONE: o_valid=1 and o_result driven. Go to IDLE unconditionally.
- Latency: start in cycle 0 gives CALC in cycles 1..XLEN, SIGN in XLEN+1, DONE (o_valid) in XLEN+2, i.e. 34 for XLEN=32. Special cases give o_valid in cycle 1.
- o_stall = (state==IDLE & i_start & ~i_flush) | state==CALC | state==SIGN. It is low in DONE so the instruction advances at the end of that cycle.
- i_start is sampled only in IDLE. In DONE it is ignored, because the same instruction is still in EX. A back-to-back M op is accepted in the following IDLE cycle.
- Multiply: 2*XLEN-bit unsigned product of the magnitudes.
  - Signedness: mul and mulh treat both operands as signed. mulhsu treats rs1 as signed and rs2 as unsigned. mulhu treats both as unsigned.
  - Product is negated if the operand signs differ (signed operands only).
  - mul returns the low XLEN bits; the other multiplies return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle on the magnitudes.
  - Quotient is negated if the signs differ (div).
  - Remainder takes the dividend sign (rem).
- Special cases (no CALC):
  - Divisor=0: div/divu return all ones; rem/remu return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): div returns 0x80000000; rem returns 0.
- i_flush=1 in any state: next state IDLE, o_valid stays 0, result discarded. Flush has priority over i_start.
- Reset mid-operation aborts immediately with no o_valid.
- o_result holds its last value outside DONE. Consumers qualify it with o_valid.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: the four multiply ops compute the full product with a single-cycle combinational multiplier in IDLE and go straight to DONE, so o_valid arrives in cycle 1. Division is unchanged.
- Undefined: all ops use the iterative path described above.

Test Plan:
- mul rs1=7, rs2=0xFFFFFFFD (-3), start cycle 0 -> o_stall=1 cycles 0..33; o_valid=1 only in cycle 34 with o_result=0xFFFFFFEB.
- mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- divu 100/7 -> 14; remu -> 2. div -7/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF. Each has o_valid in cycle 34.
- div 5/0 -> 0xFFFFFFFF and rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000 and rem -> 0. All have o_valid in cycle 1 with o_stall=1 only in cycle 0.
- divu started cycle 0, i_flush=1 in cycle 10 -> IDLE in cycle 11, o_stall=0 from cycle 11, no o_valid through cycle 40. i_rst_n pulsed low mid-CALC -> all outputs 0 immediately.
- Two consecutive ops with i_start held through DONE -> exactly one o_valid per op; the second op's o_valid comes 35 cycles after the first's.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage handshake bundle between the pipeline and the M-extension sequencer
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic            i_flush;
    logic            o_stall;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start,
        output i_funct3,
        output i_rs1_data,
        output i_rs2_data,
        output i_flush,
        input  o_stall,
        input  o_busy,
        input  o_valid,
        input  o_result
    );

    modport slave (
        input  i_start,
        input  i_funct3,
        input  i_rs1_data,
        input  i_rs2_data,
        input  i_flush,
        output o_stall,
        output o_busy,
        output o_valid,
        output o_result
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer (optional MULDIV_FAST_MUL_EN single-cycle multiply)
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    muldiv_seq_if.slave   bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        funct3_q;
    // Multiply: full product, multiplier consumed from the low end.
    // Divide: high half is the partial remainder, low half the dividend/quotient.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div_in;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              neg_in;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              fast_take;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   sign_res;

    assign accept = (state_q == S_IDLE) && bus.i_start && !bus.i_flush;

    // Operand decode: signedness, magnitudes, result sign and the no-iteration divide cases
    always_comb begin
        is_div_in = bus.i_funct3[2];
        if (!bus.i_funct3[2]) begin
            a_signed = (bus.i_funct3[1:0] != 2'b11);
            b_signed = !bus.i_funct3[1];
        end else begin
            a_signed = !bus.i_funct3[0];
            b_signed = !bus.i_funct3[0];
        end
        a_neg  = a_signed && bus.i_rs1_data[XLEN-1];
        b_neg  = b_signed && bus.i_rs2_data[XLEN-1];
        a_mag  = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
        b_mag  = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
        // Remainder follows the dividend; everything else follows the sign product.
        neg_in = (bus.i_funct3[2] && bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);

        div_by_zero = is_div_in && (bus.i_rs2_data == '0);
        div_ovf     = is_div_in && !bus.i_funct3[0] &&
                      (bus.i_rs1_data == MIN_NEG) && (bus.i_rs2_data == ALL_ONES);
        special     = div_by_zero || div_ovf;
        if (div_by_zero) begin
            special_res = bus.i_funct3[1] ? bus.i_rs1_data : ALL_ONES;
        end else begin
            special_res = bus.i_funct3[1] ? '0 : MIN_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic        [2*XLEN-1:0] fast_prod;

    // Single-cycle multiplier on sign/zero-extended operands
    always_comb begin
        fast_a    = {a_signed && bus.i_rs1_data[XLEN-1], bus.i_rs1_data};
        fast_b    = {b_signed && bus.i_rs2_data[XLEN-1], bus.i_rs2_data};
        fast_prod = (2*XLEN)'(fast_a * fast_b);
        fast_take = !is_div_in;
        fast_res  = (bus.i_funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_take = 1'b0;
    assign fast_res  = '0;
`endif

    // One radix-2 step of shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_ge   = !div_diff[XLEN];
        div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end

    // Pick the architectural result and apply the recorded sign
    always_comb begin
        prod_neg = -acc_q;
        sign_res = '0;
        case (funct3_q)
            3'b000:                 sign_res = neg_q ? prod_neg[XLEN-1:0] : acc_q[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sign_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sign_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            default:                sign_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state_d = (special || fast_take) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = S_SIGN;
                    end
                end
                S_SIGN:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pipeline-facing status outputs
    always_comb begin
        bus.o_busy  = (state_q != S_IDLE);
        bus.o_valid = (state_q == S_DONE) && !bus.i_flush;
        bus.o_stall = accept || (state_q == S_CALC) || (state_q == S_SIGN);
    end

    assign bus.o_result = result_q;

    // Datapath: latch operands, iterate, and write the final result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            funct3_q <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        funct3_q <= bus.i_funct3;
                        cnt_q    <= '0;
                        if (special) begin
                            result_q <= special_res;
                        end else if (fast_take) begin
                            result_q <= fast_res;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, a_mag};
                            b_q   <= b_mag;
                            neg_q <= neg_in;
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.i_flush) begin
                        acc_q <= funct3_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SIGN: begin
                    if (!bus.i_flush) begin
                        result_q <= sign_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed-vector bench for muldiv_seq
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          got_lat;
        logic [31:0] got_res;
        bit          stall_ok;
        got_lat  = -1;
        got_res  = 32'hDEAD_BEEF;
        stall_ok = 1'b1;
        bus.i_start    = 1'b1;
        bus.i_funct3   = f3;
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        for (int cyc = 0; cyc < 60 && got_lat < 0; cyc++) begin
            @(negedge clk);
            if (bus.o_stall !== (cyc < exp_lat)) stall_ok = 1'b0;
            if (bus.o_valid === 1'b1) begin
                got_lat = cyc;
                got_res = bus.o_result;
            end
            @(posedge clk);
            #1;
        end
        bus.i_start = 1'b0;
        check_vec({tag, ".res"}, got_res, exp_res);
        check_vec({tag, ".lat"}, got_lat, exp_lat);
        check_vec({tag, ".stall"}, {31'd0, stall_ok}, 32'd1);
        @(negedge clk);
        check_vec({tag, ".vld_after"}, {31'd0, bus.o_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int valid_cnt;
        int pos1;
        int pos2;
        logic [31:0] res1;
        logic [31:0] res2;
        bit stall_ok;

        n_vec  = 0;
        n_miss = 0;
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_funct3   = 3'b000;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("rst.stall",  {31'd0, bus.o_stall}, 32'd0);
        check_vec("rst.busy",   {31'd0, bus.o_busy},  32'd0);
        check_vec("rst.valid",  {31'd0, bus.o_valid}, 32'd0);
        check_vec("rst.result", bus.o_result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("divu",   3'b101, 32'd100,      32'd7,         32'd14,        DIV_LAT);
        run_op("remu",   3'b111, 32'd100,      32'd7,         32'd2,         DIV_LAT);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div0",   3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",   3'b110, 32'd5,        32'd0,         32'd5,         1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush in cycle 10 of a divu
        valid_cnt = 0;
        stall_ok  = 1'b1;
        bus.i_start    = 1'b1;
        bus.i_funct3   = 3'b101;
        bus.i_rs1_data = 32'd1000;
        bus.i_rs2_data = 32'd3;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) valid_cnt++;
            if (cyc >= 11 && bus.o_stall !== 1'b0) stall_ok = 1'b0;
            if (cyc == 11) check_vec("flush.busy", {31'd0, bus.o_busy}, 32'd0);
            @(posedge clk);
            #1;
            if (cyc == 9) begin
                bus.i_flush = 1'b1;
                bus.i_start = 1'b0;
            end
            if (cyc == 10) bus.i_flush = 1'b0;
        end
        check_vec("flush.valid_cnt", valid_cnt, 32'd0);
        check_vec("flush.stall", {31'd0, stall_ok}, 32'd1);

        // Reset pulse in the middle of CALC
        bus.i_start    = 1'b1;
        bus.i_funct3   = 3'b101;
        bus.i_rs1_data = 32'd1000;
        bus.i_rs2_data = 32'd3;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check_vec("midrst.busy_before", {31'd0, bus.o_busy}, 32'd1);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        #1;
        check_vec("midrst.stall",  {31'd0, bus.o_stall}, 32'd0);
        check_vec("midrst.busy",   {31'd0, bus.o_busy},  32'd0);
        check_vec("midrst.valid",  {31'd0, bus.o_valid}, 32'd0);
        check_vec("midrst.result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back ops with i_start held through DONE
        valid_cnt = 0;
        pos1 = -1;
        pos2 = -1;
        res1 = 32'hDEAD_BEEF;
        res2 = 32'hDEAD_BEEF;
        bus.i_start    = 1'b1;
        bus.i_funct3   = 3'b101;
        bus.i_rs1_data = 32'd100;
        bus.i_rs2_data = 32'd7;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                valid_cnt++;
                if (pos1 < 0) begin
                    pos1 = cyc;
                    res1 = bus.o_result;
                end else if (pos2 < 0) begin
                    pos2 = cyc;
                    res2 = bus.o_result;
                end
            end
            @(posedge clk);
            #1;
            if (cyc == pos1 && pos2 < 0) bus.i_funct3 = 3'b111;
            if (cyc == pos2) bus.i_start = 1'b0;
        end
        bus.i_start = 1'b0;
        check_vec("b2b.valid_cnt", valid_cnt, 32'd2);
        check_vec("b2b.pos1", pos1, 32'd34);
        check_vec("b2b.gap", pos2 - pos1, 32'd35);
        check_vec("b2b.res1", res1, 32'd14);
        check_vec("b2b.res2", res2, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
